// File: rtl/spi_host_link.sv
// ============================================================================
// Module  : spi_host_link
// Purpose : SPI mode-0 master that uploads a job to the subdivision ASIC,
//           polls its busy marker and downloads the result words.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module spi_host_link #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8,
    parameter int ADDR_WIDTH = 11,
    parameter int POLL_LIMIT = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [31:0]           i_in_words,
    output logic [ADDR_WIDTH-1:0] o_src_addr,
    input  logic [31:0]           i_src_data,
    output logic                  o_dst_we,
    output logic [ADDR_WIDTH-1:0] o_dst_addr,
    output logic [31:0]           o_dst_data,
    output logic [31:0]           o_result_count,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic                  o_sck,
    output logic                  o_ss_n,
    output logic                  o_mosi,
    input  logic                  i_miso
);

    localparam int c_CMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int c_CW   = $clog2(c_CMAX) + 1;
    localparam int c_PW   = $clog2(POLL_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SETUP = 3'd2,
        S_SHIFT = 3'd3,
        S_HOLD  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        P_UPLOAD   = 2'd0,
        P_POLL     = 2'd1,
        P_DOWNLOAD = 2'd2
    } phase_t;

    state_t                r_state;
    phase_t                r_phase;
    logic [c_CW-1:0]       r_cnt;
    logic [4:0]            r_bit;
    logic [31:0]           r_tx;
    logic [31:0]           r_rx;
    logic [31:0]           r_n;
    logic [31:0]           r_word;
    logic [c_PW-1:0]       r_poll;
    logic [ADDR_WIDTH-1:0] r_dl;
    logic                  r_fetch_wait;
    logic                  r_miso_meta;
    logic                  r_miso_sync;
    logic [31:0]           w_tx;

    // Word 0 of the upload carries the full count; the rest come from memory.
    always_comb begin
        w_tx = 32'h0;
        if (r_phase == P_UPLOAD) begin
            w_tx = (r_word == 32'd0) ? r_n : i_src_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_miso_meta <= 1'b0;
            r_miso_sync <= 1'b0;
        end else begin
            r_miso_meta <= i_miso;
            r_miso_sync <= r_miso_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_phase        <= P_UPLOAD;
            r_cnt          <= '0;
            r_bit          <= '0;
            r_tx           <= '0;
            r_rx           <= '0;
            r_n            <= '0;
            r_word         <= '0;
            r_poll         <= '0;
            r_dl           <= '0;
            r_fetch_wait   <= 1'b0;
            o_src_addr     <= '0;
            o_dst_we       <= 1'b0;
            o_dst_addr     <= '0;
            o_dst_data     <= '0;
            o_result_count <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_error        <= 1'b0;
            o_sck          <= 1'b0;
            o_ss_n         <= 1'b1;
            o_mosi         <= 1'b0;
        end else begin
            o_done   <= 1'b0;
            o_dst_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        o_busy       <= 1'b1;
                        o_error      <= 1'b0;
                        r_n          <= i_in_words;
                        r_phase      <= P_UPLOAD;
                        r_word       <= '0;
                        r_poll       <= '0;
                        r_fetch_wait <= 1'b0;
                        r_state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Source words need one cycle for the synchronous read to land.
                    if (r_phase == P_UPLOAD && r_word != 32'd0 && !r_fetch_wait) begin
                        r_fetch_wait <= 1'b1;
                    end else begin
                        r_fetch_wait <= 1'b0;
                        r_tx         <= w_tx;
                        o_mosi       <= w_tx[31];
                        o_ss_n       <= 1'b0;
                        r_cnt        <= '0;
                        r_state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == c_CW'(CLK_DIV - 1)) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        o_sck   <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (o_sck) begin
                        if (r_cnt == c_CW'(CLK_DIV - 2)) begin
                            r_rx <= {r_rx[30:0], r_miso_sync};
                        end
                        if (r_cnt == c_CW'(CLK_DIV - 1)) begin
                            r_cnt <= '0;
                            o_sck <= 1'b0;
                            if (r_bit != 5'd31) begin
                                o_mosi <= r_tx[5'd30 - r_bit];
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        if (r_cnt == c_CW'(CLK_DIV - 1)) begin
                            r_cnt <= '0;
                            if (r_bit == 5'd31) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_bit <= r_bit + 5'd1;
                                o_sck <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_cnt == c_CW'(CLK_DIV - 1)) begin
                        r_cnt   <= '0;
                        o_ss_n  <= 1'b1;
                        o_mosi  <= 1'b0;
                        r_state <= S_GAP;
                        if (r_phase == P_DOWNLOAD) begin
                            o_dst_we   <= 1'b1;
                            o_dst_addr <= r_dl;
                            o_dst_data <= r_rx;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == c_CW'(GAP_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_FETCH;
                        case (r_phase)
                            P_UPLOAD: begin
                                if (r_word == r_n) begin
                                    r_phase <= P_POLL;
                                end else begin
                                    o_src_addr <= r_word[ADDR_WIDTH-1:0];
                                    r_word     <= r_word + 32'd1;
                                end
                            end
                            P_POLL: begin
                                if (r_rx == 32'hFFFF_FFFF) begin
                                    if (r_poll == c_PW'(POLL_LIMIT - 1)) begin
                                        o_error <= 1'b1;
                                        o_done  <= 1'b1;
                                        o_busy  <= 1'b0;
                                        r_state <= S_IDLE;
                                    end else begin
                                        r_poll <= r_poll + 1'b1;
                                    end
                                end else begin
                                    o_result_count <= r_rx;
                                    r_dl           <= '0;
                                    r_phase        <= P_DOWNLOAD;
                                end
                            end
                            default: begin
                                // The count's low bits index the last (trailing) word.
                                if (r_dl == o_result_count[ADDR_WIDTH-1:0]) begin
                                    o_done  <= 1'b1;
                                    o_busy  <= 1'b0;
                                    r_state <= S_IDLE;
                                end else begin
                                    r_dl <= r_dl + 1'b1;
                                end
                            end
                        endcase
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_host_link.sv
// ============================================================================
// Module  : tb_spi_host_link
// Purpose : Self-checking bench for spi_host_link with an SPI device model.
// Rev     : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_host_link;

    localparam int CLK_DIV = 4;
    localparam int GAP     = 8;
    localparam int AW      = 11;
    localparam int PLIM    = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   in_words = '0;
    logic [AW-1:0] src_addr;
    logic [31:0]   src_data = '0;
    logic          dst_we;
    logic [AW-1:0] dst_addr;
    logic [31:0]   dst_data;
    logic [31:0]   result_count;
    logic          busy, done, error, sck, ss_n, mosi;
    logic          miso = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_host_link #(
        .CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP), .ADDR_WIDTH(AW), .POLL_LIMIT(PLIM)
    ) dut (
        .clk(clk), .reset(reset), .i_start(start), .i_in_words(in_words),
        .o_src_addr(src_addr), .i_src_data(src_data), .o_dst_we(dst_we),
        .o_dst_addr(dst_addr), .o_dst_data(dst_data), .o_result_count(result_count),
        .o_busy(busy), .o_done(done), .o_error(error), .o_sck(sck), .o_ss_n(ss_n),
        .o_mosi(mosi), .i_miso(miso)
    );

    // Synchronous-read source memory
    logic [31:0] src_mem [0:(1<<AW)-1];
    always @(posedge clk) src_data <= src_mem[src_addr];

    // Device model: one queued reply per select window, MSB first, mode 0
    logic [31:0] resp_q[$];
    bit          ff_forever = 1'b0;
    logic [31:0] slv_tx = '0, slv_rx = '0;
    int          slv_bits = 0;
    logic [31:0] mosi_log[$];
    int          bits_log[$];

    always @(negedge ss_n) begin
        if (resp_q.size() > 0) slv_tx = resp_q.pop_front();
        else                   slv_tx = ff_forever ? 32'hFFFF_FFFF : 32'h0;
        slv_bits = 0;
        slv_rx   = '0;
        miso <= slv_tx[31];
    end
    always @(posedge sck) if (!ss_n) begin
        slv_rx = {slv_rx[30:0], mosi};
        slv_bits++;
    end
    always @(negedge sck) if (!ss_n) begin
        slv_tx = {slv_tx[30:0], 1'b0};
        miso <= slv_tx[31];
    end
    always @(posedge ss_n) begin
        mosi_log.push_back(slv_rx);
        bits_log.push_back(slv_bits);
    end

    // Output monitor
    typedef struct { logic [AW-1:0] a; logic [31:0] d; } wr_t;
    wr_t  wr_log[$];
    int   win_len = 0, bad_win = 0, done_cnt = 0, done_busy_bad = 0;
    logic prev_ss = 1'b1;

    always @(negedge clk) begin
        wr_t w;
        if (ss_n === 1'b0) win_len++;
        else if (prev_ss === 1'b0) begin
            if (win_len != 66 * CLK_DIV) bad_win++;
            win_len = 0;
        end
        prev_ss = ss_n;
        if (dst_we) begin
            w.a = dst_addr;
            w.d = dst_data;
            wr_log.push_back(w);
        end
        if (done) begin
            done_cnt++;
            if (busy) done_busy_bad++;
        end
    end

    logic [31:0] fixed_dl[$];

    task automatic clear_logs();
        mosi_log.delete(); bits_log.delete(); wr_log.delete();
        done_cnt = 0; done_busy_bad = 0; bad_win = 0; win_len = 0;
    endtask

    // Runs one job and compares against the expected transaction list.
    task automatic run_job(input int n, input int p, input logic [31:0] m,
                           input bit timeout, input bit keep_src,
                           input bit restart_busy, input string tag);
        logic [31:0] exp_words[$];
        logic [31:0] dl[$];
        int L, budget, cyc, bad_bits;
        bit got;
        L = int'(m[AW-1:0]) + 1;
        if (!keep_src) for (int i = 0; i < n; i++) src_mem[i] = $urandom;
        resp_q.delete();
        ff_forever = timeout;
        for (int i = 0; i <= n; i++) resp_q.push_back($urandom);
        exp_words.push_back(32'(n));
        for (int i = 0; i < n; i++) exp_words.push_back(src_mem[i]);
        if (timeout) begin
            for (int i = 0; i < PLIM; i++) exp_words.push_back(32'h0);
        end else begin
            for (int i = 0; i < p; i++) resp_q.push_back(32'hFFFF_FFFF);
            resp_q.push_back(m);
            for (int j = 0; j < L; j++) begin
                dl.push_back((fixed_dl.size() == L) ? fixed_dl[j] : $urandom);
                resp_q.push_back(dl[j]);
            end
            for (int i = 0; i <= p + L; i++) exp_words.push_back(32'h0);
        end
        budget = (n + p + L + PLIM + 6) * 290 + 200;

        @(negedge clk);
        clear_logs();
        in_words = 32'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_rise: got %b exp 1", tag, busy); end
        got = 1'b0;
        for (int k = 0; k < 2 && !got; k++) begin
            @(negedge clk);
            if (ss_n === 1'b0) got = 1'b1;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL %s ss_fall: ss_n not low within 2 cycles of busy", tag); end

        if (restart_busy) begin
            repeat (300) @(negedge clk);
            in_words = 32'(n + 5);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end

        cyc = 0;
        while (done_cnt == 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        repeat (20) @(negedge clk);

        checks++;
        if (cyc >= budget) begin errors++; $display("FAIL %s done_timeout: no done in %0d cycles", tag, budget); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL %s done_count: got %0d exp 1", tag, done_cnt); end
        checks++;
        if (done_busy_bad != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL %s busy_at_done: bad=%0d busy=%b exp 0/0", tag, done_busy_bad, busy);
        end
        checks++;
        if (error !== timeout) begin errors++; $display("FAIL %s error_flag: got %b exp %b", tag, error, timeout); end
        checks++;
        if (mosi_log.size() != exp_words.size()) begin
            errors++; $display("FAIL %s word_count: got %0d exp %0d", tag, mosi_log.size(), exp_words.size());
        end
        for (int i = 0; i < mosi_log.size() && i < exp_words.size(); i++) begin
            checks++;
            if (mosi_log[i] !== exp_words[i]) begin
                errors++; $display("FAIL %s mosi_word[%0d]: got %h exp %h", tag, i, mosi_log[i], exp_words[i]);
            end
        end
        bad_bits = 0;
        foreach (bits_log[i]) if (bits_log[i] != 32) bad_bits++;
        checks++;
        if (bad_bits != 0 || bad_win != 0) begin
            errors++; $display("FAIL %s framing: bad_bits=%0d bad_windows=%0d exp 0/0", tag, bad_bits, bad_win);
        end
        if (timeout) begin
            checks++;
            if (wr_log.size() != 0) begin errors++; $display("FAIL %s dst_writes: got %0d exp 0", tag, wr_log.size()); end
        end else begin
            checks++;
            if (result_count !== m) begin errors++; $display("FAIL %s result_count: got %h exp %h", tag, result_count, m); end
            checks++;
            if (wr_log.size() != L) begin errors++; $display("FAIL %s dst_writes: got %0d exp %0d", tag, wr_log.size(), L); end
            for (int j = 0; j < wr_log.size() && j < L; j++) begin
                checks++;
                if (wr_log[j].a !== AW'(j) || wr_log[j].d !== dl[j]) begin
                    errors++; $display("FAIL %s dst[%0d]: got %h@%0d exp %h@%0d", tag, j, wr_log[j].d, wr_log[j].a, dl[j], j);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        in_words = 32'd2;
        repeat (3) @(negedge clk);
        checks++;
        if (sck !== 1'b0 || ss_n !== 1'b1 || mosi !== 1'b0) begin
            errors++; $display("FAIL reset_spi: sck=%b ss_n=%b mosi=%b exp 0 1 0", sck, ss_n, mosi);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || dst_we !== 1'b0) begin
            errors++; $display("FAIL reset_flags: busy=%b done=%b error=%b we=%b exp 0", busy, done, error, dst_we);
        end
        checks++;
        if (src_addr !== '0 || dst_addr !== '0 || dst_data !== '0 || result_count !== '0) begin
            errors++; $display("FAIL reset_regs: src=%h dst=%h data=%h cnt=%h exp 0", src_addr, dst_addr, dst_data, result_count);
        end
        start = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL start_during_reset: busy=%b exp 0", busy); end
    endtask

    task automatic test_spec_vectors();
        src_mem[0] = 32'hA5A5_A5A5;
        src_mem[1] = 32'h0000_0001;
        src_mem[2] = 32'hDEAD_BEEF;
        fixed_dl = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        run_job(3, 5, 32'd2, 1'b0, 1'b1, 1'b0, "spec_job");
        fixed_dl.delete();
    endtask

    task automatic test_timeout();
        run_job(2, 0, 32'd0, 1'b1, 1'b0, 1'b0, "timeout");
    endtask

    task automatic test_zero_words();
        run_job(0, 1, 32'd1, 1'b0, 1'b0, 1'b0, "n_zero");
    endtask

    task automatic test_reset_mid_word();
        int cyc;
        for (int i = 0; i < 3; i++) src_mem[i] = $urandom;
        resp_q.delete();
        ff_forever = 1'b0;
        @(negedge clk);
        clear_logs();
        in_words = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(mosi_log.size() == 1 && slv_bits == 17 && ss_n === 1'b0) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 5000) begin errors++; $display("FAIL abort_reach: bit 17 of word 1 not reached"); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (sck !== 1'b0 || ss_n !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_state: sck=%b ss_n=%b busy=%b exp 0 1 0", sck, ss_n, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        run_job(3, 2, 32'd1, 1'b0, 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_back_to_back();
        run_job(2, 1, 32'd2, 1'b0, 1'b0, 1'b1, "restart_busy");
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            int n, p;
            logic [31:0] m;
            n = int'($urandom_range(0, 5));
            p = int'($urandom_range(0, 4));
            m = ($urandom & 32'hFFFF_F800) | 32'($urandom_range(0, 3));
            run_job(n, p, m, 1'b0, 1'b0, 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_timeout();
        test_zero_words();
        test_reset_mid_word();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
